// File: rtl/morse_pkg.sv
// Shared constants and types for the Morse display text path.
// Letter codes, glyph geometry, command and pixel-stage bundles.
package morse_pkg;

  localparam int LETTER_W = 5;
  localparam int GLYPH_W  = 8;
  localparam int GLYPH_H  = 16;

  localparam logic [LETTER_W-1:0] BLANK_LETTER = 5'd31;

  typedef enum logic {
    SLOT_IDLE,
    SLOT_PEND
  } slot_state_e;

  typedef enum logic [1:0] {
    CMD_APPEND,
    CMD_BACKSPACE,
    CMD_CLEAR
  } cmd_op_e;

  typedef struct packed {
    cmd_op_e               op;
    logic [LETTER_W-1:0]   letter;
  } cmd_t;

  typedef struct packed {
    logic       in_band;
    logic       video_on;
    logic [2:0] bit_addr;
    logic       is_blank;
    logic       is_cursor;
  } pix_s1_t;

endpackage

// File: rtl/char_line_buf.sv
// Line buffer: NUM_CHARS letter codes, one write port, one async read
// port, and a clear-all that fills every entry with BLANK_CODE.
// Ports: clk, clear, we/waddr/wdata (write), raddr/rdata (read).
module char_line_buf
  import morse_pkg::*;
#(
  parameter int                  NUM_CHARS  = 16,
  parameter logic [LETTER_W-1:0] BLANK_CODE = BLANK_LETTER
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                we,
  input  logic [LETTER_W-1:0] waddr,
  input  logic [LETTER_W-1:0] wdata,
  input  logic [LETTER_W-1:0] raddr,
  output logic [LETTER_W-1:0] rdata
);

  localparam int AW = $clog2(NUM_CHARS);
  localparam logic [LETTER_W-1:0] NC = LETTER_W'(NUM_CHARS);

  logic [LETTER_W-1:0] mem [NUM_CHARS];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        mem[i] <= BLANK_CODE;
      end
    end else if (we && (waddr < NC)) begin
      mem[waddr[AW-1:0]] <= wdata;
    end
  end

  // Addresses past the line read as blank so the caller never
  // sees stale or undefined data.
  always_comb begin
    rdata = BLANK_CODE;
    if (raddr < NC) begin
      rdata = mem[raddr[AW-1:0]];
    end
  end

endmodule

// File: rtl/char_line_ctrl.sv
// Text-line sequencer: command slot, ROM addressing, 2-stage pixel
// pipeline and blinking cursor. Ports: video timing (x, y, video_on),
// command handshake (in_*), ROM port (rom_*), vga_r, count, full.
module char_line_ctrl
  import morse_pkg::*;
#(
  parameter int                  NUM_CHARS    = 16,
  parameter int                  ORIGIN_X     = 192,
  parameter int                  ORIGIN_Y     = 208,
  parameter logic [LETTER_W-1:0] BLANK_CODE   = BLANK_LETTER,
  parameter int                  BLINK_FRAMES = 30
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                video_on,
  input  logic [9:0]          x,
  input  logic [9:0]          y,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LETTER_W-1:0] in_letter,
  input  logic                in_clear,
  input  logic                in_backspace,
  output logic [LETTER_W-1:0] rom_letter,
  output logic [3:0]          rom_row,
  input  logic [7:0]          rom_data,
  output logic                vga_r,
  output logic [LETTER_W-1:0] count,
  output logic                full
);

  localparam logic [9:0] OX     = 10'(ORIGIN_X);
  localparam logic [9:0] OX_END = 10'(ORIGIN_X + GLYPH_W * NUM_CHARS);
  localparam logic [9:0] OY     = 10'(ORIGIN_Y);
  localparam logic [9:0] OY_END = 10'(ORIGIN_Y + GLYPH_H);
  localparam logic [LETTER_W-1:0] NC = LETTER_W'(NUM_CHARS);
  localparam int FW = (BLINK_FRAMES < 2) ? 1 : $clog2(BLINK_FRAMES);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  slot_state_e state, state_n;
  cmd_t        cmd_q;
  cmd_op_e     op_in;

  logic                safe;
  logic                accept;
  logic                apply;
  logic                buf_clr;
  logic                buf_we;
  logic [LETTER_W-1:0] buf_waddr;
  logic [LETTER_W-1:0] buf_wdata;
  logic [LETTER_W-1:0] buf_rdata;
  logic [LETTER_W-1:0] count_n;
  logic [LETTER_W-1:0] col;
  logic                in_band;
  logic [FW-1:0]       frame_cnt;
  logic                blink_on;
  pix_s1_t             s1, s1_n;

  // Edits only land outside the text band so a line is never
  // drawn half-updated.
  assign safe     = (y < OY) || (y >= OY_END);
  assign in_ready = (state == SLOT_IDLE);
  assign full     = (count == NC);
  assign accept   = in_valid && in_ready;
  assign apply    = (state == SLOT_PEND) && safe;

  always_comb begin
    op_in = CMD_APPEND;
    priority case (1'b1)
      in_clear:     op_in = CMD_CLEAR;
      in_backspace: op_in = CMD_BACKSPACE;
      default:      op_in = CMD_APPEND;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SLOT_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      SLOT_IDLE: if (accept) state_n = SLOT_PEND;
      SLOT_PEND: if (safe)   state_n = SLOT_IDLE;
      default:               state_n = SLOT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q <= '{op: CMD_APPEND, letter: BLANK_CODE};
    end else if (accept) begin
      cmd_q <= '{op: op_in, letter: in_letter};
    end
  end

  always_comb begin
    buf_clr   = 1'b0;
    buf_we    = 1'b0;
    buf_waddr = count;
    buf_wdata = BLANK_CODE;
    count_n   = count;
    if (apply) begin
      unique case (cmd_q.op)
        CMD_CLEAR: begin
          buf_clr = 1'b1;
          count_n = '0;
        end
        CMD_BACKSPACE: begin
          if (count != '0) begin
            buf_we    = 1'b1;
            buf_waddr = count - LETTER_W'(1);
            count_n   = count - LETTER_W'(1);
          end
        end
        default: begin
          if (!full) begin
            buf_we    = 1'b1;
            buf_wdata = cmd_q.letter;
            count_n   = count + LETTER_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_n;
    end
  end

  char_line_buf #(
    .NUM_CHARS  (NUM_CHARS),
    .BLANK_CODE (BLANK_CODE)
  ) u_buf (
    .clk   (clk),
    .clear (reset || buf_clr),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (buf_wdata),
    .raddr (col),
    .rdata (buf_rdata)
  );

  assign col     = LETTER_W'((x - OX) >> 3);
  assign in_band = (x >= OX) && (x < OX_END) && !safe;

  assign rom_letter = in_band ? buf_rdata : BLANK_CODE;
  assign rom_row    = y[3:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else if ((x == '0) && (y == '0)) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end

  // Cursor is an underline on the last glyph row of the next
  // write slot; a full line has no next slot.
  always_comb begin
    s1_n           = '0;
    s1_n.in_band   = in_band;
    s1_n.video_on  = video_on;
    s1_n.bit_addr  = x[2:0];
    s1_n.is_blank  = (rom_letter == BLANK_CODE);
    s1_n.is_cursor = (col == count) && (y[3:0] == 4'hF)
                     && blink_on && !full;
  end

  // rom_data arrives one cycle after the address, alongside s1.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= '0;
      vga_r <= 1'b0;
    end else begin
      s1    <= s1_n;
      vga_r <= s1.video_on && s1.in_band
               && ((rom_data[3'd7 - s1.bit_addr] && !s1.is_blank)
                   || s1.is_cursor);
    end
  end

endmodule

// File: tb/tb_char_line_ctrl.sv
// Scoreboard bench for char_line_ctrl: stimulus queues expected values
// with a due cycle; a negedge monitor compares them against the DUT.
module tb_char_line_ctrl;

  localparam int K_VGA = 0;
  localparam int K_CNT = 1;
  localparam int K_RDY = 2;
  localparam int K_ROM = 3;
  localparam int K_FULL = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       video_on;
  logic [9:0] x, y;
  logic       in_valid, in_ready;
  logic [4:0] in_letter;
  logic       in_clear, in_backspace;
  logic [4:0] rom_letter;
  logic [3:0] rom_row;
  logic [7:0] rom_data;
  logic       vga_r;
  logic [4:0] count;
  logic       full;

  char_line_ctrl #(
    .NUM_CHARS    (16),
    .ORIGIN_X     (192),
    .ORIGIN_Y     (208),
    .BLANK_CODE   (5'd31),
    .BLINK_FRAMES (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .video_on     (video_on),
    .x            (x),
    .y            (y),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_letter    (in_letter),
    .in_clear     (in_clear),
    .in_backspace (in_backspace),
    .rom_letter   (rom_letter),
    .rom_row      (rom_row),
    .rom_data     (rom_data),
    .vga_r        (vga_r),
    .count        (count),
    .full         (full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub ROM, one cycle latency: letter 0 is a single left pixel,
  // the blank code returns all ones to expose missing blank masking.
  always @(posedge clk) begin
    if (rom_letter == 5'd0)       rom_data <= 8'h80;
    else if (rom_letter == 5'd31) rom_data <= 8'hFF;
    else                          rom_data <= 8'h00;
  end

  typedef struct {
    int    due;
    int    kind;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic push_exp(input int due, input int kind,
                          input int val, input string nm);
    exp_t e;
    e.due = due; e.kind = kind; e.val = val; e.name = nm;
    sb.push_back(e);
  endtask

  function automatic int actual(input int kind);
    case (kind)
      K_VGA:  return int'(vga_r);
      K_CNT:  return int'(count);
      K_RDY:  return int'(in_ready);
      K_ROM:  return int'(rom_letter);
      default: return int'(full);
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        checks++;
        if (sb[i].due < cyc || actual(sb[i].kind) != sb[i].val) begin
          failures++;
          $display("FAIL %s cyc=%0d got=%0d want=%0d",
                   sb[i].name, cyc, actual(sb[i].kind), sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [4:0] l, input logic c, input logic b,
                     input int expc, input string nm);
    in_valid = 1'b1; in_letter = l; in_clear = c; in_backspace = b;
    step();
    in_valid = 1'b0; in_clear = 1'b0; in_backspace = 1'b0;
    push_exp(cyc, K_RDY, 0, {nm, "_busy"});
    step();
    push_exp(cyc, K_RDY, 1, {nm, "_ready"});
    push_exp(cyc, K_CNT, expc, {nm, "_count"});
  endtask

  task automatic pix(input int xx, input int yy, input logic vo,
                     input int e, input string nm);
    x = 10'(xx); y = 10'(yy); video_on = vo;
    push_exp(cyc + 2, K_VGA, e, nm);
    step();
  endtask

  task automatic romchk(input int xx, input int yy, input int e,
                        input string nm);
    x = 10'(xx); y = 10'(yy);
    push_exp(cyc, K_ROM, e, nm);
    step();
  endtask

  initial begin
    reset = 1'b1; video_on = 1'b0; x = 10'd700; y = 10'd100;
    in_valid = 1'b0; in_letter = '0; in_clear = 1'b0; in_backspace = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    push_exp(cyc, K_RDY, 1, "rst_ready");
    push_exp(cyc, K_CNT, 0, "rst_count");
    push_exp(cyc, K_FULL, 0, "rst_full");
    push_exp(cyc, K_VGA, 0, "rst_vga");
    romchk(192, 208, 31, "rst_rom");
    y = 10'd100; x = 10'd700;

    cmd(5'd0, 1'b0, 1'b0, 1, "appA");
    cmd(5'd1, 1'b0, 1'b0, 2, "appB");
    romchk(192, 208, 0, "rom_col0");
    romchk(200, 208, 1, "rom_col1");
    romchk(216, 208, 31, "rom_col3");
    romchk(191, 208, 31, "rom_left");
    x = 10'd700; y = 10'd210;

    // Accept inside the band: held until the first safe row.
    in_valid = 1'b1; in_letter = 5'd2;
    step();
    in_valid = 1'b0;
    for (int yy = 211; yy <= 224; yy++) begin
      y = 10'(yy);
      push_exp(cyc, K_RDY, 0, $sformatf("band_busy_y%0d", yy));
      push_exp(cyc, K_CNT, 2, $sformatf("band_count_y%0d", yy));
      step();
    end
    push_exp(cyc, K_RDY, 1, "band_ready");
    push_exp(cyc, K_CNT, 3, "band_applied");
    y = 10'd100;
    step();

    pix(192, 208, 1'b1, 1, "px_on");
    pix(192, 208, 1'b0, 0, "px_video_off");
    pix(193, 208, 1'b1, 0, "px_bit1");
    pix(200, 208, 1'b1, 0, "px_letterB");
    pix(216, 208, 1'b1, 0, "px_blank");
    pix(100, 208, 1'b1, 0, "px_out_x");
    pix(192, 100, 1'b1, 0, "px_out_y");
    pix(192, 208, 1'b1, 1, "px_on2");
    pix(220, 223, 1'b1, 1, "px_cursor");
    pix(220, 222, 1'b1, 0, "px_cursor_row");
    pix(700, 100, 1'b0, 0, "px_idle");
    step();

    cmd(5'd0, 1'b0, 1'b1, 2, "bs3");
    romchk(208, 208, 31, "bs_entry2");
    romchk(200, 208, 1, "bs_entry1");
    x = 10'd700; y = 10'd100;
    cmd(5'd0, 1'b1, 1'b1, 0, "clr_bs");
    romchk(192, 208, 31, "clr_entry0");
    x = 10'd700; y = 10'd100;
    cmd(5'd0, 1'b0, 1'b1, 0, "bs_empty");

    for (int i = 0; i < 16; i++) begin
      cmd(5'(i), 1'b0, 1'b0, i + 1, $sformatf("fill%0d", i));
    end
    push_exp(cyc, K_FULL, 1, "full_set");
    cmd(5'd7, 1'b0, 1'b0, 16, "overflow");
    push_exp(cyc, K_FULL, 1, "full_kept");
    romchk(312, 208, 15, "entry15_kept");
    pix(312, 223, 1'b1, 0, "no_cursor_full");
    x = 10'd700; y = 10'd100; video_on = 1'b0;
    step();

    cmd(5'd0, 1'b1, 1'b0, 0, "clr2");
    cmd(5'd0, 1'b0, 1'b0, 1, "app_blink");
    for (int f = 0; f < 8; f++) begin
      pix(204, 223, 1'b1, ((f / 2) % 2 == 0) ? 1 : 0,
          $sformatf("blink_f%0d", f));
      x = 10'd0; y = 10'd0; video_on = 1'b0;
      step();
      x = 10'd700; y = 10'd100;
      step();
    end

    // Reset while a command waits in the band drops it.
    y = 10'd210;
    in_valid = 1'b1; in_letter = 5'd5;
    step();
    in_valid = 1'b0;
    push_exp(cyc, K_RDY, 0, "mid_busy");
    reset = 1'b1;
    step();
    reset = 1'b0;
    push_exp(cyc, K_RDY, 1, "mid_ready");
    push_exp(cyc, K_CNT, 0, "mid_count");
    romchk(192, 208, 31, "mid_entry0");
    y = 10'd100; x = 10'd700;
    repeat (2) step();
    push_exp(cyc, K_CNT, 0, "mid_dropped");

    for (int g = 0; g < 20 && sb.size() > 0; g++) step();
    if (sb.size() != 0) begin
      failures += sb.size();
      $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
